pcs_sync: RTL and testbench
===========================

PCS_SYNC -- requirements
Module: pcs_sync

Interface
REQ-001 SHALL provide rx_clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL provide mr_main_reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-003 SHALL provide signal_detect, input, 1, PMA signal present (1 = present).
REQ-004 SHALL provide pudi, input, 10, received code group from PMA, bit 9 = 'a' ... bit 0 = 'j' (same ordering as code_group_constants.v).
REQ-005 SHALL provide sudi, output, 11, {code_group[9:0], even}, consumed by pcs_receive.
REQ-006 SHALL provide sync_status, output, 1, 1 = code-group synchronization acquired.
REQ-007 SHALL provide rx_even, output, 1, current even/odd alignment flag (1 = last code group even).

Function
REQ-008 SHALL classify comma = (pudi[9:3] == 7'b0011111) or (pudi[9:3] == 7'b1100000).
REQ-009 SHALL classify valid = pudi matches any data or control code group in code_group_constants.v (either running disparity); no running-disparity error checking.
REQ-010 SHALL define cgbad = !valid or (comma and rx_even==1); cggood = !cgbad.
REQ-011 SHALL implement states LOSS_OF_SYNC, COMMA_DETECT_1/2/3, ACQUIRE_SYNC_1/2, SYNC_ACQUIRED_1, _2, _2A, _3, _3A, _4, _4A.
REQ-012 SHALL force next state LOSS_OF_SYNC whenever signal_detect==0, overriding all other transitions.
REQ-013 LOSS_OF_SYNC: comma -> COMMA_DETECT_1; else stay.
REQ-014 COMMA_DETECT_n: valid non-comma data code group -> ACQUIRE_SYNC_n (n=1,2) or SYNC_ACQUIRED_1 (n=3); anything else -> LOSS_OF_SYNC.
REQ-015 ACQUIRE_SYNC_n: cgbad -> LOSS_OF_SYNC; comma with rx_even==0 -> COMMA_DETECT_(n+1); other cggood -> stay.
REQ-016 SYNC_ACQUIRED_1: cgbad -> SYNC_ACQUIRED_2; cggood -> stay.
REQ-017 SYNC_ACQUIRED_k (k=2,3,4): clear good_cgs; cgbad -> SYNC_ACQUIRED_(k+1) (k=4: LOSS_OF_SYNC); cggood -> SYNC_ACQUIRED_kA with good_cgs=1.
REQ-018 SYNC_ACQUIRED_kA: cgbad -> SYNC_ACQUIRED_(k+1) (k=4: LOSS_OF_SYNC); cggood with good_cgs==3 -> SYNC_ACQUIRED_(k-1) (k=2: SYNC_ACQUIRED_1); cggood otherwise -> stay, good_cgs+1.
REQ-019 good_cgs SHALL be a 2-bit saturating-free counter, never exceeding 3.
REQ-020 rx_even SHALL be set to 1 on entry to any COMMA_DETECT_n and inverted on every other clock edge (all other states, including LOSS_OF_SYNC).
REQ-021 sudi SHALL register {pudi, new rx_even value} on each edge: one-cycle latency, sudi[0] equals rx_even after the same edge.
REQ-022 sync_status SHALL be registered, 1 exactly when the state is any SYNC_ACQUIRED_*, 0 otherwise.

Reset
REQ-023 While mr_main_reset==0: state LOSS_OF_SYNC, good_cgs=0, rx_even=0, sync_status=0, sudi=11'b0, immediately without clock.
REQ-024 Reset asserted mid-sync SHALL drop sync_status to 0 asynchronously; after release, acquisition restarts from LOSS_OF_SYNC.

Verification
REQ-025 Reset: mr_main_reset=0 with toggling pudi -> sync_status=0, sudi=0, rx_even=0 throughout.
REQ-026 Acquisition: signal_detect=1, three /K28.5/D16.2/ pairs -> sync_status=1 after edge sampling 6th group; sudi[0] = 1,0,1,0,1,0; sudi[10:1] = pudi delayed one cycle.
REQ-027 Single error: synced, one 10'b0000000000 then four valid idles -> sync_status stays 1; state returns SYNC_ACQUIRED_1 after 4th good.
REQ-028 Loss: synced, four invalid groups each separated by fewer than 4 good groups -> sync_status=0 after edge sampling 4th bad.
REQ-029 Misaligned comma: in ACQUIRE_SYNC_1, K28.5 presented while rx_even==1 -> LOSS_OF_SYNC next edge, sync_status stays 0.
REQ-030 Signal drop: synced, signal_detect=0 for one cycle -> sync_status=0 next edge; async mr_main_reset=0 mid-packet -> outputs zero immediately.

Source files
------------

// File: rtl/pcs_sync.sv
// Code-group synchronization for a 1000BASE-X PCS receive path.
// Tracks comma alignment, qualifies code groups and reports sync_status.
module pcs_sync (
    input  logic        rx_clk,
    input  logic        mr_main_reset,
    input  logic        signal_detect,
    input  logic [9:0]  pudi,
    output logic [10:0] sudi,
    output logic        sync_status,
    output logic        rx_even
);

    typedef enum logic [3:0] {
        LOSS_OF_SYNC    = 4'd0,
        COMMA_DETECT_1  = 4'd1,
        ACQUIRE_SYNC_1  = 4'd2,
        COMMA_DETECT_2  = 4'd3,
        ACQUIRE_SYNC_2  = 4'd4,
        COMMA_DETECT_3  = 4'd5,
        SYNC_ACQUIRED_1 = 4'd6,
        SYNC_ACQUIRED_2 = 4'd7,
        SYNC_ACQUIRED_2A = 4'd8,
        SYNC_ACQUIRED_3 = 4'd9,
        SYNC_ACQUIRED_3A = 4'd10,
        SYNC_ACQUIRED_4 = 4'd11,
        SYNC_ACQUIRED_4A = 4'd12
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_good_cgs;
    logic [1:0]  w_next_good_cgs;
    logic        r_rx_even;
    logic        w_next_rx_even;
    logic        w_next_sync;
    logic        r_sync_status;
    logic [10:0] r_sudi;
    logic        w_comma;
    logic        w_data;
    logic        w_valid;
    logic        w_cgbad;
    logic        w_cggood;

    function automatic logic [2:0] pop6(input logic [5:0] c);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 6; i++) begin
            n = n + {2'b00, c[i]};
        end
        return n;
    endfunction

    // 6b sub-blocks legal when the running disparity entering them is negative
    function automatic logic six_ok_neg(input logic [5:0] c);
        logic ok;
        case (c)
            6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
            6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100,
            6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b011011, 6'b100011,
            6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
            6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
            6'b011110, 6'b101011: ok = 1'b1;
            default:              ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic six_ok_pos(input logic [5:0] c);
        logic ok;
        case (c)
            6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001,
            6'b011001, 6'b000111, 6'b000110, 6'b100101, 6'b010101, 6'b110100,
            6'b001101, 6'b101100, 6'b011100, 6'b101000, 6'b100100, 6'b100011,
            6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
            6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001,
            6'b100001, 6'b010100: ok = 1'b1;
            default:              ok = 1'b0;
        endcase
        return ok;
    endfunction

    // use_a7 selects the alternate D.x.7 encoding that avoids a run of five
    function automatic logic four_ok(input logic [3:0] f, input logic rd_pos,
                                     input logic use_a7);
        logic ok;
        if (!rd_pos) begin
            case (f)
                4'b1011, 4'b1001, 4'b0101, 4'b1100,
                4'b1101, 4'b1010, 4'b0110: ok = 1'b1;
                4'b0111:                   ok = use_a7;
                4'b1110:                   ok = !use_a7;
                default:                   ok = 1'b0;
            endcase
        end else begin
            case (f)
                4'b0100, 4'b1001, 4'b0101, 4'b0011,
                4'b0010, 4'b1010, 4'b0110: ok = 1'b1;
                4'b1000:                   ok = use_a7;
                4'b0001:                   ok = !use_a7;
                default:                   ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    function automatic logic is_data(input logic [9:0] cg);
        logic [5:0] six;
        logic [3:0] four;
        logic [2:0] ones;
        logic       a7_neg;
        logic       a7_pos;
        logic       rd_mid_n;
        logic       rd_mid_p;
        six      = cg[9:4];
        four     = cg[3:0];
        ones     = pop6(six);
        a7_neg   = (six == 6'b100011) || (six == 6'b010011) || (six == 6'b001011);
        a7_pos   = (six == 6'b110100) || (six == 6'b101100) || (six == 6'b011100);
        rd_mid_n = (ones == 3'd4);
        rd_mid_p = (ones != 3'd2);
        return (six_ok_neg(six) && four_ok(four, rd_mid_n, rd_mid_n ? a7_pos : a7_neg)) ||
               (six_ok_pos(six) && four_ok(four, rd_mid_p, rd_mid_p ? a7_pos : a7_neg));
    endfunction

    function automatic logic is_ctrl(input logic [9:0] cg);
        logic ok;
        case (cg)
            10'b0011110100, 10'b0011111001, 10'b0011110101, 10'b0011110011,
            10'b0011110010, 10'b0011111010, 10'b0011110110, 10'b0011111000,
            10'b1100001011, 10'b1100000110, 10'b1100001010, 10'b1100001100,
            10'b1100001101, 10'b1100000101, 10'b1100001001, 10'b1100000111,
            10'b1110101000, 10'b1101101000, 10'b1011101000, 10'b0111101000,
            10'b0001010111, 10'b0010010111, 10'b0100010111, 10'b1000010111: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Code-group classification against the current alignment
    always_comb begin
        w_comma  = (pudi[9:3] == 7'b0011111) || (pudi[9:3] == 7'b1100000);
        w_data   = is_data(pudi);
        w_valid  = w_data || is_ctrl(pudi);
        w_cgbad  = !w_valid || (w_comma && r_rx_even);
        w_cggood = !w_cgbad;
    end

    // Next-state, good_cgs and alignment decode
    always_comb begin
        w_next_state    = r_state;
        w_next_good_cgs = r_good_cgs;
        case (r_state)
            LOSS_OF_SYNC: begin
                if (w_comma) w_next_state = COMMA_DETECT_1;
                else         w_next_state = LOSS_OF_SYNC;
            end
            COMMA_DETECT_1, COMMA_DETECT_2, COMMA_DETECT_3: begin
                if (w_data && !w_comma) begin
                    if (r_state == COMMA_DETECT_1)      w_next_state = ACQUIRE_SYNC_1;
                    else if (r_state == COMMA_DETECT_2) w_next_state = ACQUIRE_SYNC_2;
                    else                                w_next_state = SYNC_ACQUIRED_1;
                end else begin
                    w_next_state = LOSS_OF_SYNC;
                end
            end
            ACQUIRE_SYNC_1, ACQUIRE_SYNC_2: begin
                if (w_cgbad) begin
                    w_next_state = LOSS_OF_SYNC;
                end else if (w_comma && !r_rx_even) begin
                    w_next_state = (r_state == ACQUIRE_SYNC_1) ? COMMA_DETECT_2 : COMMA_DETECT_3;
                end else begin
                    w_next_state = r_state;
                end
            end
            SYNC_ACQUIRED_1: begin
                if (w_cgbad) w_next_state = SYNC_ACQUIRED_2;
                else         w_next_state = SYNC_ACQUIRED_1;
            end
            SYNC_ACQUIRED_2, SYNC_ACQUIRED_3, SYNC_ACQUIRED_4: begin
                w_next_good_cgs = 2'd0;
                if (w_cgbad) begin
                    if (r_state == SYNC_ACQUIRED_2)      w_next_state = SYNC_ACQUIRED_3;
                    else if (r_state == SYNC_ACQUIRED_3) w_next_state = SYNC_ACQUIRED_4;
                    else                                 w_next_state = LOSS_OF_SYNC;
                end else begin
                    w_next_good_cgs = 2'd1;
                    if (r_state == SYNC_ACQUIRED_2)      w_next_state = SYNC_ACQUIRED_2A;
                    else if (r_state == SYNC_ACQUIRED_3) w_next_state = SYNC_ACQUIRED_3A;
                    else                                 w_next_state = SYNC_ACQUIRED_4A;
                end
            end
            SYNC_ACQUIRED_2A, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4A: begin
                if (w_cgbad) begin
                    if (r_state == SYNC_ACQUIRED_2A)      w_next_state = SYNC_ACQUIRED_3;
                    else if (r_state == SYNC_ACQUIRED_3A) w_next_state = SYNC_ACQUIRED_4;
                    else                                  w_next_state = LOSS_OF_SYNC;
                end else if (r_good_cgs == 2'd3) begin
                    w_next_good_cgs = 2'd0;
                    if (r_state == SYNC_ACQUIRED_2A)      w_next_state = SYNC_ACQUIRED_1;
                    else if (r_state == SYNC_ACQUIRED_3A) w_next_state = SYNC_ACQUIRED_2;
                    else                                  w_next_state = SYNC_ACQUIRED_3;
                end else begin
                    w_next_good_cgs = r_good_cgs + 2'd1;
                    w_next_state    = r_state;
                end
            end
            default: begin
                w_next_state    = LOSS_OF_SYNC;
                w_next_good_cgs = 2'd0;
            end
        endcase

        if (!signal_detect) begin
            w_next_state = LOSS_OF_SYNC;
        end else begin
            w_next_state = w_next_state;
        end

        if ((w_next_state == COMMA_DETECT_1) || (w_next_state == COMMA_DETECT_2) ||
            (w_next_state == COMMA_DETECT_3)) begin
            w_next_rx_even = 1'b1;
        end else begin
            w_next_rx_even = !r_rx_even;
        end

        w_next_sync = (w_next_state == SYNC_ACQUIRED_1)  || (w_next_state == SYNC_ACQUIRED_2)  ||
                      (w_next_state == SYNC_ACQUIRED_2A) || (w_next_state == SYNC_ACQUIRED_3)  ||
                      (w_next_state == SYNC_ACQUIRED_3A) || (w_next_state == SYNC_ACQUIRED_4)  ||
                      (w_next_state == SYNC_ACQUIRED_4A);
    end

    // State and output registers; sudi carries the alignment decided on this edge
    always_ff @(posedge rx_clk or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            r_state       <= LOSS_OF_SYNC;
            r_good_cgs    <= 2'd0;
            r_rx_even     <= 1'b0;
            r_sync_status <= 1'b0;
            r_sudi        <= 11'd0;
        end else begin
            r_state       <= w_next_state;
            r_good_cgs    <= w_next_good_cgs;
            r_rx_even     <= w_next_rx_even;
            r_sync_status <= w_next_sync;
            r_sudi        <= {pudi, w_next_rx_even};
        end
    end

    assign sudi        = r_sudi;
    assign sync_status = r_sync_status;
    assign rx_even     = r_rx_even;

endmodule

// File: tb/tb_pcs_sync.sv
// Directed self-checking bench for pcs_sync.
module tb_pcs_sync;

    localparam logic [9:0] K285 = 10'b0011111010;
    localparam logic [9:0] K280 = 10'b0011110100;
    localparam logic [9:0] D162 = 10'b0110110101;
    localparam logic [9:0] BAD  = 10'b0000000000;

    logic        rx_clk;
    logic        mr_main_reset;
    logic        signal_detect;
    logic [9:0]  pudi;
    logic [10:0] sudi;
    logic        sync_status;
    logic        rx_even;

    int n_cmp = 0;
    int n_bad = 0;

    pcs_sync dut (
        .rx_clk        (rx_clk),
        .mr_main_reset (mr_main_reset),
        .signal_detect (signal_detect),
        .pudi          (pudi),
        .sudi          (sudi),
        .sync_status   (sync_status),
        .rx_even       (rx_even)
    );

    initial rx_clk = 1'b0;
    always #5 rx_clk = ~rx_clk;

    task automatic cyc(input logic [9:0] code, input logic sd);
        pudi          = code;
        signal_detect = sd;
        @(posedge rx_clk);
        #1;
    endtask

    // Acquire from any state: force loss, then three aligned idle pairs.
    task automatic sync_up();
        cyc(D162, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(K285, 1'b1);
            cyc(D162, 1'b1);
        end
        n_cmp++;
        if (sync_status !== 1'b1) begin
            n_bad++;
            $display("FAIL sync_up: sync_status=%b expected 1", sync_status);
        end
    endtask

    task automatic test_reset();
        mr_main_reset = 1'b0;
        signal_detect = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc((i % 2 == 0) ? K285 : D162, 1'b1);
            n_cmp++;
            if (sync_status !== 1'b0 || sudi !== 11'd0 || rx_even !== 1'b0) begin
                n_bad++;
                $display("FAIL reset[%0d]: sync=%b sudi=%b even=%b expected 0/0/0",
                         i, sync_status, sudi, rx_even);
            end
        end
        mr_main_reset = 1'b1;
    endtask

    task automatic test_acquisition();
        logic [9:0] seq [0:5];
        logic       exp_even;
        logic       exp_sync;
        seq = '{K285, D162, K285, D162, K285, D162};
        for (int i = 0; i < 6; i++) begin
            cyc(seq[i], 1'b1);
            exp_even = (i % 2 == 0) ? 1'b1 : 1'b0;
            exp_sync = (i == 5) ? 1'b1 : 1'b0;
            n_cmp++;
            if (sudi !== {seq[i], exp_even}) begin
                n_bad++;
                $display("FAIL acq_sudi[%0d]: got %b expected %b", i, sudi, {seq[i], exp_even});
            end
            n_cmp++;
            if (sync_status !== exp_sync) begin
                n_bad++;
                $display("FAIL acq_sync[%0d]: got %b expected %b", i, sync_status, exp_sync);
            end
        end
    endtask

    // One bad then four goods must return to SYNC_ACQUIRED_1: three more bads keep sync, fourth drops it.
    task automatic test_single_error();
        logic [9:0] seq [0:8];
        logic       exp_sync [0:8];
        sync_up();
        seq      = '{BAD, D162, D162, D162, D162, BAD, BAD, BAD, BAD};
        exp_sync = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 9; i++) begin
            cyc(seq[i], 1'b1);
            n_cmp++;
            if (sync_status !== exp_sync[i]) begin
                n_bad++;
                $display("FAIL single_err[%0d]: sync=%b expected %b", i, sync_status, exp_sync[i]);
            end
        end
    endtask

    task automatic test_loss();
        logic [9:0] seq [0:9];
        logic       exp_sync [0:9];
        sync_up();
        seq      = '{BAD, D162, D162, BAD, D162, BAD, D162, D162, D162, BAD};
        exp_sync = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            cyc(seq[i], 1'b1);
            n_cmp++;
            if (sync_status !== exp_sync[i]) begin
                n_bad++;
                $display("FAIL loss[%0d]: sync=%b expected %b", i, sync_status, exp_sync[i]);
            end
        end
    endtask

    task automatic test_misaligned();
        cyc(D162, 1'b0);
        cyc(K285, 1'b1);
        cyc(D162, 1'b1);
        cyc(D162, 1'b1);
        cyc(K285, 1'b1);
        n_cmp++;
        if (rx_even !== 1'b0 || sync_status !== 1'b0) begin
            n_bad++;
            $display("FAIL misaligned: even=%b sync=%b expected 0/0", rx_even, sync_status);
        end
        for (int i = 0; i < 6; i++) begin
            cyc((i % 2 == 0) ? K285 : D162, 1'b1);
            n_cmp++;
            if (sync_status !== ((i == 5) ? 1'b1 : 1'b0)) begin
                n_bad++;
                $display("FAIL misaligned_reacq[%0d]: sync=%b expected %b",
                         i, sync_status, (i == 5) ? 1'b1 : 1'b0);
            end
        end
    endtask

    // A data group in COMMA_DETECT_1 lets acquisition finish; anything else restarts it.
    task automatic test_valid_table();
        logic [9:0] vec [0:10];
        logic       exp_ok [0:10];
        vec    = '{10'b1001110100, 10'b1001111011, 10'b1000110111, 10'b1000111110,
                   10'b1110100001, 10'b1110101000, 10'b0001110011, 10'b1101001000,
                   10'b1111111111, 10'b1100011001, K280};
        exp_ok = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 11; i++) begin
            cyc(D162, 1'b0);
            cyc(K285, 1'b1);
            cyc(vec[i], 1'b1);
            cyc(K285, 1'b1);
            cyc(D162, 1'b1);
            cyc(K285, 1'b1);
            cyc(D162, 1'b1);
            n_cmp++;
            if (sync_status !== exp_ok[i]) begin
                n_bad++;
                $display("FAIL valid_tbl[%0d] code=%b: sync=%b expected %b",
                         i, vec[i], sync_status, exp_ok[i]);
            end
        end
    endtask

    task automatic test_signal_drop();
        sync_up();
        cyc(D162, 1'b0);
        n_cmp++;
        if (sync_status !== 1'b0) begin
            n_bad++;
            $display("FAIL sig_drop: sync=%b expected 0", sync_status);
        end
        sync_up();
        cyc(K285, 1'b1);
        cyc(D162, 1'b1);
        #2;
        mr_main_reset = 1'b0;
        #1;
        n_cmp++;
        if (sync_status !== 1'b0 || sudi !== 11'd0 || rx_even !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: sync=%b sudi=%b even=%b expected 0/0/0",
                     sync_status, sudi, rx_even);
        end
        cyc(K285, 1'b1);
        mr_main_reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc((i % 2 == 0) ? K285 : D162, 1'b1);
            n_cmp++;
            if (sync_status !== ((i == 5) ? 1'b1 : 1'b0)) begin
                n_bad++;
                $display("FAIL post_reset_acq[%0d]: sync=%b expected %b",
                         i, sync_status, (i == 5) ? 1'b1 : 1'b0);
            end
        end
    endtask

    initial begin
        mr_main_reset = 1'b0;
        signal_detect = 1'b0;
        pudi          = 10'd0;
        test_reset();
        test_acquisition();
        test_single_error();
        test_loss();
        test_misaligned();
        test_valid_table();
        test_signal_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
